// File: rtl/image_arith_pipe.sv
// image_arith_pipe: combines two packed multi-channel pixels under a
// runtime-selected operation, with valid/ready handshakes on both sides.
// Simple ops finish one cycle after capture. DIV uses an iterative
// restoring divider that produces one quotient bit per cycle.
// Every channel result saturates to [0, 2^DATA_WIDTH-1].
// Optional feature macro: IMG_ARITH_DIV_EN compiles in the divider.
// Without it, op 4 passes pixel_a through with simple-op latency.

module image_arith_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int SHIFT      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] pixel_a,
    input  logic [CHANNELS*DATA_WIDTH-1:0] pixel_b,
    input  logic [DATA_WIDTH-1:0]          alpha,
    input  logic [2:0]                     op,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] pixel_out,
    output logic                           div_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = CHANNELS * DATA_WIDTH;
    // Wide enough for (a << SHIFT) and for a*b without overflow
    localparam int IW = W + SHIFT + W;
    localparam logic [W-1:0] MAXV = {W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   a_r;
    logic [PW-1:0]   b_r;
    logic [W-1:0]    alpha_r;
    logic [2:0]      op_r;
    logic [PW-1:0]   pixel_out_r;
    logic            out_valid_r;
    logic            div_zero_r;
    logic [PW-1:0]   simple_res_s;
    logic            accept_s;

    // Clamp a wide intermediate to the channel range
    function automatic logic [W-1:0] sat_f(input logic [IW-1:0] v);
        if (v > IW'(MAXV)) begin
            return MAXV;
        end else begin
            return v[W-1:0];
        end
    endfunction

    // One channel of every single-cycle operation; op 4 falls through
    // to pass-through, which is the divider-less behaviour
    function automatic logic [W-1:0] simple_op_f(input logic [2:0] o,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input logic [W-1:0] al);
        logic [IW-1:0] ea;
        logic [IW-1:0] eb;
        logic [IW-1:0] eal;
        logic [IW-1:0] r;
        ea  = IW'(a);
        eb  = IW'(b);
        eal = IW'(al);
        case (o)
            3'd0:    r = ea + eb;
            3'd1:    r = (ea > eb) ? (ea - eb) : '0;
            3'd2:    r = (ea > eb) ? (ea - eb) : (eb - ea);
            3'd3:    r = (ea * eb) >> SHIFT;
            3'd5:    r = ((ea * eal) + (eb * (IW'(MAXV) - eal))) >> W;
            3'd6:    r = (ea > eb) ? ea : eb;
            3'd7:    r = (ea < eb) ? ea : eb;
            default: r = ea;
        endcase
        return sat_f(r);
    endfunction

    // Ready in IDLE, or in DONE when the held result is being retired
    assign in_ready  = ~rst & ((state_r == IDLE) | ((state_r == DONE) & out_ready));
    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_r;
    assign pixel_out = pixel_out_r;
    assign div_zero  = div_zero_r;

    // Per-channel results of all single-cycle operations
    always_comb begin
        simple_res_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            simple_res_s[c*W +: W] = simple_op_f(op_r, a_r[c*W +: W], b_r[c*W +: W], alpha_r);
        end
    end

`ifdef IMG_ARITH_DIV_EN
    localparam int N  = W + SHIFT;
    localparam int CW = $clog2(N + 1);

    // dq_r starts as the scaled dividend and shifts left one bit per step;
    // quotient bits enter at the bottom, so after N steps it holds the quotient
    logic [W-1:0]  rem_r     [CHANNELS];
    logic [N-1:0]  dq_r      [CHANNELS];
    logic [W:0]    trial_s   [CHANNELS];
    logic [W-1:0]  rem_nxt_s [CHANNELS];
    logic [N-1:0]  dq_nxt_s  [CHANNELS];
    logic [PW-1:0] div_res_s;
    logic          div_zero_s;
    logic [CW-1:0] cnt_r;
    logic          div_last_s;

    assign div_last_s = (cnt_r == CW'(N - 1));

    // One restoring-division step per channel plus the saturated result
    always_comb begin
        div_res_s  = '0;
        div_zero_s = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            trial_s[c] = {rem_r[c], dq_r[c][N-1]};
            if (trial_s[c] >= {1'b0, b_r[c*W +: W]}) begin
                rem_nxt_s[c] = W'(trial_s[c] - {1'b0, b_r[c*W +: W]});
                dq_nxt_s[c]  = {dq_r[c][N-2:0], 1'b1};
            end else begin
                rem_nxt_s[c] = trial_s[c][W-1:0];
                dq_nxt_s[c]  = {dq_r[c][N-2:0], 1'b0};
            end
            if (b_r[c*W +: W] == '0) begin
                div_res_s[c*W +: W] = MAXV;
                div_zero_s          = 1'b1;
            end else begin
                div_res_s[c*W +: W] = sat_f(IW'(dq_nxt_s[c]));
            end
        end
    end

    // Load the scaled dividend on accept, then iterate while a DIV is in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                rem_r[c] <= '0;
                dq_r[c]  <= '0;
            end
            cnt_r <= '0;
        end else if (accept_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
                rem_r[c] <= '0;
                dq_r[c]  <= {pixel_a[c*W +: W], {SHIFT{1'b0}}};
            end
            cnt_r <= '0;
        end else if ((state_r == EXEC) && (op_r == 3'd4)) begin
            for (int c = 0; c < CHANNELS; c++) begin
                rem_r[c] <= rem_nxt_s[c];
                dq_r[c]  <= dq_nxt_s[c];
            end
            cnt_r <= cnt_r + CW'(1);
        end
    end
`endif

    // Capture operands on every accepted beat; they are used only as captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            alpha_r <= '0;
            op_r    <= 3'd0;
        end else if (accept_s) begin
            a_r     <= pixel_a;
            b_r     <= pixel_b;
            alpha_r <= alpha;
            op_r    <= op;
        end
    end

    // Control FSM and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            pixel_out_r <= '0;
            div_zero_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
`ifdef IMG_ARITH_DIV_EN
                    if (op_r == 3'd4) begin
                        if (div_last_s) begin
                            pixel_out_r <= div_res_s;
                            div_zero_r  <= div_zero_s;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end
                    end else begin
                        pixel_out_r <= simple_res_s;
                        div_zero_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
`else
                    pixel_out_r <= simple_res_s;
                    div_zero_r  <= 1'b0;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
`endif
                end
                DONE: begin
                    // Result is held until retired; a beat arriving on the
                    // retiring edge goes straight to EXEC
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= accept_s ? EXEC : IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_arith_pipe.sv
// Self-checking bench for image_arith_pipe: a transaction-level reference
// model predicts handshakes, latency and per-channel results, and a
// negedge compare process checks the DUT against it every cycle.
// Hand-computed literal cases pin the model. Follows IMG_ARITH_DIV_EN.

`timescale 1ns/1ps

module tb_image_arith_pipe;

    localparam int W     = 8;
    localparam int CH    = 3;
    localparam int SHIFT = 4;
    localparam int PW    = W * CH;
    localparam int MAXI  = (1 << W) - 1;
`ifdef IMG_ARITH_DIV_EN
    localparam int DIV_LAT = W + SHIFT + 1;
`else
    localparam int DIV_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] pixel_a;
    logic [PW-1:0] pixel_b;
    logic [W-1:0]  alpha;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] pixel_out;
    logic          div_zero;

    int checks = 0;
    int errors = 0;

    // model state
    int            edge_cnt = 0;
    bit            busy = 1'b0;
    int            due = 0;
    logic [PW-1:0] exp_pix = '0;
    logic          exp_dz = 1'b0;
    int            n_in = 0;
    int            n_out = 0;

    image_arith_pipe #(.DATA_WIDTH(W), .CHANNELS(CH), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel_a   (pixel_a),
        .pixel_b   (pixel_b),
        .alpha     (alpha),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pixel_out (pixel_out),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the operation definitions, plain integers
    task automatic model(input logic [2:0] o, input logic [PW-1:0] a, input logic [PW-1:0] b,
                         input logic [W-1:0] al, output logic [PW-1:0] r, output logic dz);
        int ia, ib, ial, v;
        r   = '0;
        dz  = 1'b0;
        ial = int'(al);
        for (int c = 0; c < CH; c++) begin
            ia = int'(a[c*W +: W]);
            ib = int'(b[c*W +: W]);
            case (o)
                3'd0: v = ia + ib;
                3'd1: v = (ia > ib) ? ia - ib : 0;
                3'd2: v = (ia > ib) ? ia - ib : ib - ia;
                3'd3: v = (ia * ib) / (1 << SHIFT);
`ifdef IMG_ARITH_DIV_EN
                3'd4: begin
                    if (ib == 0) begin
                        v  = MAXI;
                        dz = 1'b1;
                    end else begin
                        v = (ia * (1 << SHIFT)) / ib;
                    end
                end
`else
                3'd4: v = ia;
`endif
                3'd5: v = (ia * ial + ib * (MAXI - ial)) / (1 << W);
                3'd6: v = (ia > ib) ? ia : ib;
                3'd7: v = (ia < ib) ? ia : ib;
                default: v = 0;
            endcase
            r[c*W +: W] = (v > MAXI) ? W'(MAXI) : W'(v);
        end
    endtask

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // Compare process: predicts and checks outputs just before each edge
    always @(negedge clk) begin
        int  k;
        bit  exp_ov, exp_ir;
        logic [PW-1:0] r;
        logic          dz;
        if (rst) begin
            busy = 1'b0;
            chk("rst in_ready", in_ready, 0);
            chk("rst out_valid", out_valid, 0);
            chk("rst pixel_out", pixel_out, 0);
            chk("rst div_zero", div_zero, 0);
        end else begin
            k      = edge_cnt + 1;
            exp_ov = busy && (k >= due);
            exp_ir = !busy || (exp_ov && out_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, exp_ir);
            if (exp_ov) begin
                chk("pixel_out", pixel_out, exp_pix);
                chk("div_zero", div_zero, exp_dz);
            end
            if (exp_ov && out_ready) begin
                busy  = 1'b0;
                n_out = n_out + 1;
            end
            if (in_valid && exp_ir) begin
                model(op, pixel_a, pixel_b, alpha, r, dz);
                exp_pix = r;
                exp_dz  = dz;
                busy    = 1'b1;
                due     = k + ((op == 3'd4) ? DIV_LAT : 2);
                n_in    = n_in + 1;
            end
        end
    end

    // Present a beat and hold it until an edge accepts it (bounded)
    task automatic drive_beat(input logic [2:0] o, input logic [PW-1:0] a, input logic [PW-1:0] b,
                              input logic [W-1:0] al, output logic ok);
        pixel_a  = a;
        pixel_b  = b;
        alpha    = al;
        op       = o;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
    endtask

    // One beat with hand-computed result and latency
    task automatic lit(input string nm, input logic [2:0] o, input logic [PW-1:0] a,
                       input logic [PW-1:0] b, input logic [W-1:0] al,
                       input logic [PW-1:0] ep, input logic edz, input int elat);
        logic ok;
        int   lat;
        out_ready = 1'b1;
        drive_beat(o, a, b, al, ok);
        chk({nm, " accept"}, ok, 1);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, lat, elat);
        chk({nm, " pixel"}, pixel_out, ep);
        chk({nm, " div_zero"}, div_zero, edz);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input bit allow_div);
        pixel_a = PW'($urandom);
        for (int c = 0; c < CH; c++)
            pixel_b[c*W +: W] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        alpha = W'($urandom);
        op    = 3'($urandom_range(0, 7));
        if (!allow_div && op == 3'd4) op = 3'd0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        int   n0, waited;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        pixel_a = '0; pixel_b = '0; alpha = '0; op = 3'd0;
        @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset pixel_out", pixel_out, 0);
        chk("reset div_zero", div_zero, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("in_ready after release", in_ready, 1);

        lit("ADD", 3'd0, {8'd255, 8'd10, 8'd200}, {8'd1, 8'd20, 8'd100}, 8'd0,
            {8'd255, 8'd30, 8'd255}, 1'b0, 2);
        lit("SUB", 3'd1, {8'd255, 8'd10, 8'd200}, {8'd1, 8'd20, 8'd100}, 8'd0,
            {8'd254, 8'd0, 8'd100}, 1'b0, 2);
        lit("MUL", 3'd3, {8'd0, 8'd255, 8'd20}, {8'd9, 8'd255, 8'd30}, 8'd0,
            {8'd0, 8'd255, 8'd37}, 1'b0, 2);
        lit("BLEND", 3'd5, {8'd200, 8'd200, 8'd200}, {8'd0, 8'd0, 8'd0}, 8'd255,
            {8'd199, 8'd199, 8'd199}, 1'b0, 2);
        lit("ABSDIFF", 3'd2, {8'd0, 8'd60, 8'd10}, {8'd0, 8'd10, 8'd60}, 8'd0,
            {8'd0, 8'd50, 8'd50}, 1'b0, 2);
        lit("MAX", 3'd6, {8'd50, 8'd200, 8'd1}, {8'd50, 8'd100, 8'd2}, 8'd0,
            {8'd50, 8'd200, 8'd2}, 1'b0, 2);
        lit("MIN", 3'd7, {8'd50, 8'd200, 8'd1}, {8'd50, 8'd100, 8'd2}, 8'd0,
            {8'd50, 8'd100, 8'd1}, 1'b0, 2);
`ifdef IMG_ARITH_DIV_EN
        lit("DIV", 3'd4, {8'd7, 8'd255, 8'd100}, {8'd0, 8'd1, 8'd50}, 8'd0,
            {8'd255, 8'd255, 8'd32}, 1'b1, 13);
`else
        lit("DIV off", 3'd4, {8'd7, 8'd255, 8'd100}, {8'd0, 8'd1, 8'd50}, 8'd0,
            {8'd7, 8'd255, 8'd100}, 1'b0, 2);
`endif

        // Backpressure: result held, new beats refused
        out_ready = 1'b0;
        rand_inputs(1'b0);
        drive_beat(op, pixel_a, pixel_b, alpha, ok);
        chk("bp accept", ok, 1);
        waited = 0;
        while (!out_valid && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("bp result valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            rand_inputs(1'b1);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end

        // Continuous stream of simple ops: one result per two cycles
        out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 40; i++) begin
            rand_inputs(1'b0);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("stream throughput", ((n_out - n0) >= 19) && ((n_out - n0) <= 21), 1);

        // Random traffic including DIV and backpressure
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no loss or duplication", n_in, n_out);

        // Reset in the middle of a DIV beat
        drive_beat(3'd4, {8'd7, 8'd255, 8'd100}, {8'd0, 8'd1, 8'd50}, 8'd0, ok);
        chk("div accept", ok, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst pixel_out", pixel_out, 0);
        chk("midrst in_ready", in_ready, 0);
        chk("midrst div_zero", div_zero, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready after midrst", in_ready, 1);
        lit("ADD after rst", 3'd0, {8'd3, 8'd128, 8'd100}, {8'd4, 8'd128, 8'd27}, 8'd0,
            {8'd7, 8'd255, 8'd127}, 1'b0, 2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
